// File: rtl/qpd_frame_buffer_if.sv
// rtl/qpd_frame_buffer_if.sv - demod capture / processor drain bus for qpd_frame_buffer (decim_i present under QPD_FRAME_DECIM_EN)
interface qpd_frame_buffer_if #(
  parameter int DATA_W = 24,
  parameter int DEPTH  = 64,
  parameter int OVF_W  = 16
);
  logic                      tick_i;
  logic signed [DATA_W-1:0]  x1_i;
  logic signed [DATA_W-1:0]  x2_i;
  logic signed [DATA_W-1:0]  i1_i;
  logic signed [DATA_W-1:0]  i2_i;
  logic                      clear_i;
  logic                      rd_req_i;
`ifdef QPD_FRAME_DECIM_EN
  logic [7:0]                decim_i;
`endif
  logic                      rd_valid_o;
  logic [31:0]               rd_seq_o;
  logic [31:0]               rd_x1_o;
  logic [31:0]               rd_x2_o;
  logic [31:0]               rd_i1_o;
  logic [31:0]               rd_i2_o;
  logic [$clog2(DEPTH):0]    level_o;
  logic                      empty_o;
  logic                      full_o;
  logic [OVF_W-1:0]          ovf_cnt_o;

  modport master (
`ifdef QPD_FRAME_DECIM_EN
    output decim_i,
`endif
    output tick_i, x1_i, x2_i, i1_i, i2_i, clear_i, rd_req_i,
    input  rd_valid_o, rd_seq_o, rd_x1_o, rd_x2_o, rd_i1_o, rd_i2_o,
    input  level_o, empty_o, full_o, ovf_cnt_o
  );

  modport slave (
`ifdef QPD_FRAME_DECIM_EN
    input  decim_i,
`endif
    input  tick_i, x1_i, x2_i, i1_i, i2_i, clear_i, rd_req_i,
    output rd_valid_o, rd_seq_o, rd_x1_o, rd_x2_o, rd_i1_o, rd_i2_o,
    output level_o, empty_o, full_o, ovf_cnt_o
  );
endinterface

// File: rtl/qpd_frame_buffer.sv
// rtl/qpd_frame_buffer.sv - sequence-numbered circular frame FIFO after the QPD demodulator; tick decimation under QPD_FRAME_DECIM_EN
module qpd_frame_buffer #(
  parameter int DATA_W = 24,
  parameter int DEPTH  = 64,
  parameter int OVF_W  = 16
) (
  input logic               clk,
  input logic               reset,
  qpd_frame_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int FW = 32 + 4 * DATA_W;

  // Frame layout in RAM: {seq, x1, x2, i1, i2}
  logic [FW-1:0]    mem [DEPTH];
  logic [FW-1:0]    rd_q;
  logic             rd_valid;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    level;
  logic [31:0]      seq;
  logic [OVF_W-1:0] ovf_cnt;
  logic             empty;
  logic             full;
  logic             accept;
  logic             do_wr;
  logic             do_rd;
  logic             do_ovf;

  function automatic logic [31:0] sext(input logic [DATA_W-1:0] v);
    return {{(32 - DATA_W){v[DATA_W-1]}}, v};
  endfunction

  assign empty = (level == '0);
  assign full  = (level == LW'(DEPTH));

`ifdef QPD_FRAME_DECIM_EN
  logic [7:0] phase;
  logic [7:0] decim_q;

  assign accept = bus.tick_i && (phase == 8'd0);

  // Decimation phase: a tick is accepted at phase 0; the ratio is latched on each accepted tick
  always_ff @(posedge clk) begin
    if (reset || bus.clear_i) begin
      phase   <= 8'd0;
      decim_q <= 8'd0;
    end else if (bus.tick_i) begin
      if (phase == 8'd0) begin
        decim_q <= bus.decim_i;
        phase   <= (bus.decim_i == 8'd0) ? 8'd0 : 8'd1;
      end else begin
        phase   <= (phase == decim_q) ? 8'd0 : phase + 8'd1;
      end
    end
  end
`else
  assign accept = bus.tick_i;
`endif

  // Clear beats both sides; a pop on a full FIFO frees the slot for a same-cycle write
  always_comb begin
    do_rd  = bus.rd_req_i && !empty && !bus.clear_i;
    do_wr  = accept && !bus.clear_i && (!full || do_rd);
    do_ovf = accept && !bus.clear_i && full && !do_rd;
  end

  // Sequence counter advances on every tick so software can see decimated and dropped frames
  always_ff @(posedge clk) begin
    if (reset) begin
      seq <= 32'd0;
    end else if (bus.tick_i) begin
      seq <= seq + 32'd1;
    end
  end

  // Pointers, fill level and saturating overflow count
  always_ff @(posedge clk) begin
    if (reset || bus.clear_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      ovf_cnt <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      if (do_wr && !do_rd) begin
        level <= level + LW'(1);
      end else if (do_rd && !do_wr) begin
        level <= level - LW'(1);
      end
      if (do_ovf && (ovf_cnt != {OVF_W{1'b1}})) begin
        ovf_cnt <= ovf_cnt + OVF_W'(1);
      end
    end
  end

  // RAM write port
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= {seq, bus.x1_i, bus.x2_i, bus.i1_i, bus.i2_i};
    end
  end

  // RAM read port doubles as the output register; reads old data when the same slot is rewritten
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q     <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= do_rd;
      if (do_rd) begin
        rd_q <= mem[rd_ptr];
      end
    end
  end

  assign bus.rd_valid_o = rd_valid;
  assign bus.rd_seq_o   = rd_q[FW-1 -: 32];
  assign bus.rd_x1_o    = sext(rd_q[4*DATA_W-1 -: DATA_W]);
  assign bus.rd_x2_o    = sext(rd_q[3*DATA_W-1 -: DATA_W]);
  assign bus.rd_i1_o    = sext(rd_q[2*DATA_W-1 -: DATA_W]);
  assign bus.rd_i2_o    = sext(rd_q[DATA_W-1:0]);
  assign bus.level_o    = level;
  assign bus.empty_o    = empty;
  assign bus.full_o     = full;
  assign bus.ovf_cnt_o  = ovf_cnt;
endmodule

// File: tb/tb_qpd_frame_buffer.sv
// tb/tb_qpd_frame_buffer.sv - self-checking bench for qpd_frame_buffer against a queue-based frame model
module tb_qpd_frame_buffer;
  localparam int DATA_W  = 24;
  localparam int DEPTH   = 64;
  localparam int OVF_W   = 4;
  localparam int OVF_MAX = (1 << OVF_W) - 1;

  typedef struct {
    logic [31:0] seq;
    logic [31:0] x1;
    logic [31:0] x2;
    logic [31:0] i1;
    logic [31:0] i2;
  } frame_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  qpd_frame_buffer_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .OVF_W(OVF_W)) bus ();

  qpd_frame_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .OVF_W(OVF_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  frame_t      q[$];
  frame_t      m_out;
  bit          m_valid;
  logic [31:0] m_seq;
  int          m_ovf;
  int          m_skip;
  int          decim;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] sext(input logic signed [DATA_W-1:0] v);
    logic signed [31:0] e;
    e = v;
    return e;
  endfunction

  task automatic set_data(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                          input logic [DATA_W-1:0] c, input logic [DATA_W-1:0] d);
    bus.x1_i = a;
    bus.x2_i = b;
    bus.i1_i = c;
    bus.i2_i = d;
  endtask

  task automatic rand_data();
    set_data(DATA_W'($urandom()), DATA_W'($urandom()), DATA_W'($urandom()), DATA_W'($urandom()));
  endtask

  // One clock: drive inputs, advance the model at the edge, compare every output just after it
  task automatic cycle(input bit rst, input bit tk, input bit clr, input bit rd);
    frame_t f;
    bit     acc;
    reset        = rst;
    bus.tick_i   = tk;
    bus.clear_i  = clr;
    bus.rd_req_i = rd;
`ifdef QPD_FRAME_DECIM_EN
    bus.decim_i  = 8'(decim);
`endif
    f.x1 = sext(bus.x1_i);
    f.x2 = sext(bus.x2_i);
    f.i1 = sext(bus.i1_i);
    f.i2 = sext(bus.i2_i);
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_seq   = 32'd0;
      m_ovf   = 0;
      m_out   = '{default: 32'd0};
      m_valid = 1'b0;
      m_skip  = 0;
    end else begin
      acc = tk;
`ifdef QPD_FRAME_DECIM_EN
      if (tk) begin
        if (m_skip == 0) m_skip = decim;
        else begin
          acc = 1'b0;
          m_skip--;
        end
      end
`endif
      f.seq   = m_seq;
      if (tk) m_seq = m_seq + 32'd1;
      m_valid = 1'b0;
      if (clr) begin
        q.delete();
        m_ovf  = 0;
        m_skip = 0;
      end else begin
        if (rd && q.size() > 0) begin
          m_out   = q.pop_front();
          m_valid = 1'b1;
        end
        if (acc) begin
          if (q.size() < DEPTH) q.push_back(f);
          else if (m_ovf < OVF_MAX) m_ovf++;
        end
      end
    end
    #1;
    check("rd_valid", bus.rd_valid_o, m_valid);
    check("level", bus.level_o, q.size());
    check("empty", bus.empty_o, q.size() == 0);
    check("full", bus.full_o, q.size() == DEPTH);
    check("ovf_cnt", bus.ovf_cnt_o, m_ovf);
    check("rd_seq", bus.rd_seq_o, m_out.seq);
    check("rd_x1", bus.rd_x1_o, m_out.x1);
    check("rd_x2", bus.rd_x2_o, m_out.x2);
    check("rd_i1", bus.rd_i1_o, m_out.i1);
    check("rd_i2", bus.rd_i2_o, m_out.i2);
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    decim = 0;
    rand_data();
    do_reset();
    check("rst_empty", bus.empty_o, 1'b1);
    check("rst_full", bus.full_o, 1'b0);

    // three frames with x1 edge values, drained in order
    set_data(24'h000001, 24'h0, 24'h0, 24'h0); cycle(0, 1, 0, 0);
    set_data(24'hFFFFFF, 24'h0, 24'h0, 24'h0); cycle(0, 1, 0, 0);
    set_data(24'h7FFFFF, 24'h0, 24'h0, 24'h0); cycle(0, 1, 0, 0);
    cycle(0, 0, 0, 1);
    check("t1_seq0", bus.rd_seq_o, 32'd0);
    check("t1_x1_0", bus.rd_x1_o, 32'h00000001);
    cycle(0, 0, 0, 1);
    check("t1_seq1", bus.rd_seq_o, 32'd1);
    check("t1_x1_1", bus.rd_x1_o, 32'hFFFFFFFF);
    cycle(0, 0, 0, 1);
    check("t1_seq2", bus.rd_seq_o, 32'd2);
    check("t1_x1_2", bus.rd_x1_o, 32'h007FFFFF);
    check("t1_empty", bus.empty_o, 1'b1);

    // overfill by two, then drain
    do_reset();
    for (int i = 0; i < 66; i++) begin
      rand_data();
      cycle(0, 1, 0, 0);
    end
    check("t2_full", bus.full_o, 1'b1);
    check("t2_level", bus.level_o, 64);
    check("t2_ovf", bus.ovf_cnt_o, 2);
    for (int i = 0; i < 64; i++) begin
      cycle(0, 0, 0, 1);
      check("t2_drain_seq", bus.rd_seq_o, i);
    end

    // full FIFO with simultaneous tick and pop
    do_reset();
    for (int i = 0; i < 64; i++) begin
      rand_data();
      cycle(0, 1, 0, 0);
    end
    rand_data();
    cycle(0, 1, 0, 1);
    check("t3_level", bus.level_o, 64);
    check("t3_ovf", bus.ovf_cnt_o, 0);
    check("t3_pop_seq", bus.rd_seq_o, 0);
    for (int i = 0; i < 64; i++) cycle(0, 0, 0, 1);
    check("t3_last_seq", bus.rd_seq_o, 64);

    // empty FIFO with simultaneous tick and pop: no fall-through
    do_reset();
    rand_data();
    cycle(0, 1, 0, 1);
    check("t4_valid", bus.rd_valid_o, 1'b0);
    check("t4_level", bus.level_o, 1);
    cycle(0, 0, 0, 1);
    check("t4_pop_valid", bus.rd_valid_o, 1'b1);
    check("t4_pop_seq", bus.rd_seq_o, 0);

    // clear with a same-cycle tick consumes a sequence number
    do_reset();
    for (int i = 0; i < 5; i++) begin
      rand_data();
      cycle(0, 1, 0, 0);
    end
    cycle(0, 1, 1, 0);
    check("t5_level", bus.level_o, 0);
    check("t5_ovf", bus.ovf_cnt_o, 0);
    rand_data();
    cycle(0, 1, 0, 0);
    cycle(0, 0, 0, 1);
    check("t5_seq", bus.rd_seq_o, 6);

`ifdef QPD_FRAME_DECIM_EN
    // decimation by 4
    decim = 3;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      rand_data();
      cycle(0, 1, 0, 0);
    end
    check("t6_level", bus.level_o, 3);
    check("t6_ovf", bus.ovf_cnt_o, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 1);
      check("t6_seq", bus.rd_seq_o, 4 * i);
    end
    decim = 0;
`endif

    // randomized traffic alternating fill-biased and drain-biased phases
    do_reset();
    for (int i = 0; i < 2500; i++) begin
      bit fill;
      fill = ((i / 400) % 2) == 0;
`ifdef QPD_FRAME_DECIM_EN
      if ((i % 300) == 0) decim = $urandom_range(0, 3);
`endif
      rand_data();
      cycle($urandom_range(0, 599) == 0,
            $urandom_range(0, 99) < (fill ? 75 : 30),
            $urandom_range(0, 149) == 0,
            $urandom_range(0, 99) < (fill ? 35 : 80));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
